// File: rtl/aes_bus_master.sv
// Bus initiator for the AES peripheral: writes a 128-bit message and key as four 32-bit words each,
// pulses initiate, waits a fixed latency, then reads four ciphertext words back.
module aes_bus_master #(
  parameter int AES_LATENCY = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic [0:127] msg_in,
  input  logic [0:127] key_in,
  output logic [0:127] cipher,
  output logic         done,
  output logic         CS,
  output logic         RW,
  output logic         adress,
  output logic         initiate,
  inout  wire  [31:0]  data
);

  // state    | meaning
  // S_IDLE   | ready, waiting for start
  // S_WR_MSG | writing message words 0..3 (adress=0)
  // S_WR_KEY | writing key words 0..3 (adress=1)
  // S_START  | one-cycle initiate pulse
  // S_WAIT   | down-counting AES_LATENCY cycles
  // S_RD     | reading ciphertext words 0..3
  // S_DONE   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WR_MSG, S_WR_KEY, S_START, S_WAIT, S_RD, S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [1:0]    cnt_n;
  logic [7:0]    wait_cnt;
  logic [0:127]  msg_q;
  logic [0:127]  key_q;
  logic [31:0]   wdata;

  assign cnt_n = cnt + 2'd1;

  // CS and RW are registers, so the driver releases in the same cycle they drop.
  assign data = (CS && RW) ? wdata : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      wait_cnt <= 8'd0;
      msg_q    <= '0;
      key_q    <= '0;
      wdata    <= '0;
      cipher   <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      CS       <= 1'b0;
      RW       <= 1'b0;
      adress   <= 1'b0;
      initiate <= 1'b0;
    end else begin
      done     <= 1'b0;
      initiate <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            msg_q  <= msg_in;
            key_q  <= key_in;
            cipher <= '0;
            ready  <= 1'b0;
            CS     <= 1'b1;
            RW     <= 1'b1;
            adress <= 1'b0;
            wdata  <= msg_in[0:31];
            cnt    <= 2'd0;
            state  <= S_WR_MSG;
          end
        end
        S_WR_MSG: begin
          cnt <= cnt_n;
          if (cnt == 2'd3) begin
            adress <= 1'b1;
            wdata  <= key_q[{cnt_n, 5'd0} +: 32];
            state  <= S_WR_KEY;
          end else begin
            wdata <= msg_q[{cnt_n, 5'd0} +: 32];
          end
        end
        S_WR_KEY: begin
          cnt <= cnt_n;
          if (cnt == 2'd3) begin
            CS       <= 1'b0;
            RW       <= 1'b0;
            adress   <= 1'b0;
            initiate <= 1'b1;
            state    <= S_START;
          end else begin
            wdata <= key_q[{cnt_n, 5'd0} +: 32];
          end
        end
        S_START: begin
          cnt <= 2'd0;
          if (AES_LATENCY == 0) begin
            CS    <= 1'b1;
            state <= S_RD;
          end else begin
            wait_cnt <= 8'(AES_LATENCY - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 8'd0) begin
            CS    <= 1'b1;
            state <= S_RD;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        S_RD: begin
          cipher[{cnt, 5'd0} +: 32] <= data;
          cnt <= cnt_n;
          if (cnt == 2'd3) begin
            CS    <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master: FIPS-197 vector, held start, abort in WR_KEY, zero latency
// and a bus-ownership monitor, with a responder model answering reads on each bus.
module tb_aes_bus_master;

  localparam logic [0:127] FIPS_MSG = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [0:127] msg = '0;
  logic [0:127] key = '0;

  logic         ready_a, done_a, cs_a, rw_a, adr_a, init_a;
  logic         ready_b, done_b, cs_b, rw_b, adr_b, init_b;
  logic [0:127] cipher_a, cipher_b;
  wire  [31:0]  data_a, data_b;

  logic [1:0]   rd_idx_a = 2'd0;
  logic [1:0]   rd_idx_b = 2'd0;
  logic [31:0]  resp_a, resp_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int init_cnt_a = 0;
  int done_cnt_a = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_bus_master #(.AES_LATENCY(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ready(ready_a),
    .msg_in(msg), .key_in(key), .cipher(cipher_a), .done(done_a),
    .CS(cs_a), .RW(rw_a), .adress(adr_a), .initiate(init_a), .data(data_a)
  );

  aes_bus_master #(.AES_LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ready(ready_b),
    .msg_in(msg), .key_in(key), .cipher(cipher_b), .done(done_b),
    .CS(cs_b), .RW(rw_b), .adress(adr_b), .initiate(init_b), .data(data_b)
  );

  // Responder: word k of the ciphertext on the k-th read cycle after initiate.
  assign resp_a = FIPS_CT[{rd_idx_a, 5'd0} +: 32];
  assign resp_b = FIPS_CT[{rd_idx_b, 5'd0} +: 32];
  assign data_a = (cs_a && !rw_a) ? resp_a : 'z;
  assign data_b = (cs_b && !rw_b) ? resp_b : 'z;

  always @(posedge clk) begin
    if (reset || init_a) rd_idx_a <= 2'd0;
    else if (cs_a && !rw_a) rd_idx_a <= rd_idx_a + 2'd1;
    if (reset || init_b) rd_idx_b <= 2'd0;
    else if (cs_b && !rw_b) rd_idx_b <= rd_idx_b + 2'd1;
  end

  // Undriven bus reads as z (4-state) or 0 (2-state); anything else while CS=0 means the DUT drives it.
  always @(negedge clk) begin
    if (init_a) init_cnt_a++;
    if (done_a) done_cnt_a++;
    if (!cs_a && data_a !== 32'h0 && data_a !== {32{1'bz}}) viol++;
    if (!cs_b && data_b !== 32'h0 && data_b !== {32{1'bz}}) viol++;
    if (cs_a && !rw_a && data_a !== resp_a) viol++;
    if (cs_b && !rw_b && data_b !== resp_b) viol++;
    if (cs_a && !rw_a && adr_a) viol++;
    if (cs_b && !rw_b && adr_b) viol++;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready_a !== 1'b1 || cs_a !== 1'b0 || init_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b cs=%b init=%b done=%b, required 1 0 0 0",
               ready_a, cs_a, init_a, done_a);
    end
    checks++;
    if (cipher_a !== 128'h0) begin
      failures++;
      $display("FAIL reset_cipher: got %h, required 0", cipher_a);
    end
    checks++;
    if (data_a !== 32'h0 && data_a !== {32{1'bz}}) begin
      failures++;
      $display("FAIL reset_data: got %h, required z", data_a);
    end
  endtask

  task automatic test_fips();
    logic [31:0] words[8];
    logic        adrs[8];
    int n = 0;
    int t0;
    int t_done = -1;
    int init0;
    msg = FIPS_MSG;
    key = FIPS_KEY;
    init0 = init_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 60 && t_done < 0; i++) begin
      if (cs_a && rw_a) begin
        if (n < 8) begin
          words[n] = data_a;
          adrs[n]  = adr_a;
        end
        n++;
      end
      if (done_a) t_done = cyc;
      if (t_done < 0) @(negedge clk);
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL fips_write_count: got %0d, required 8", n);
    end
    for (int k = 0; k < 8 && k < n; k++) begin
      checks++;
      if (k < 4 ? (words[k] !== FIPS_MSG[32*k +: 32] || adrs[k] !== 1'b0)
                : (words[k] !== FIPS_KEY[32*(k-4) +: 32] || adrs[k] !== 1'b1)) begin
        failures++;
        $display("FAIL fips_word%0d: got %h adress=%b, required %h adress=%0d", k, words[k], adrs[k],
                 k < 4 ? FIPS_MSG[32*k +: 32] : FIPS_KEY[32*(k-4) +: 32], k < 4 ? 0 : 1);
      end
    end
    checks++;
    if (t_done - t0 !== 24) begin
      failures++;
      $display("FAIL fips_latency: got %0d cycles, required 24", t_done - t0);
    end
    @(negedge clk);
    checks++;
    if (init_cnt_a - init0 !== 1) begin
      failures++;
      $display("FAIL fips_initiate: got %0d pulses, required 1", init_cnt_a - init0);
    end
    checks++;
    if (cipher_a !== FIPS_CT) begin
      failures++;
      $display("FAIL fips_cipher: got %h, required %h", cipher_a, FIPS_CT);
    end
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL fips_idle_after: ready=%b done=%b, required 1 0", ready_a, done_a);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int d1 = -1;
    int d2 = -1;
    int init0;
    int init_at_d1 = 0;
    logic rdy_after = 1'b0;
    logic cs_after = 1'b0;
    init0 = init_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 80 && d2 < 0; i++) begin
      @(negedge clk);
      if (done_a && d1 < 0) begin
        d1 = cyc;
        init_at_d1 = init_cnt_a;
      end else if (done_a && d1 >= 0) begin
        d2 = cyc;
      end
      if (d1 >= 0 && cyc == d1 + 1) rdy_after = ready_a;
      if (d1 >= 0 && cyc == d1 + 2) begin
        cs_after = cs_a;
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    checks++;
    if (d1 - t0 !== 24) begin
      failures++;
      $display("FAIL held_first_latency: got %0d, required 24", d1 - t0);
    end
    checks++;
    if (init_at_d1 - init0 !== 1) begin
      failures++;
      $display("FAIL held_single_txn: got %0d initiates before done, required 1", init_at_d1 - init0);
    end
    checks++;
    if (rdy_after !== 1'b1 || cs_after !== 1'b1) begin
      failures++;
      $display("FAIL held_restart: ready=%b cs=%b after done, required 1 1", rdy_after, cs_after);
    end
    checks++;
    if (d2 - d1 !== 25) begin
      failures++;
      $display("FAIL held_second_done: got %0d cycles after first done, required 25", d2 - d1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int init0;
    int done0;
    logic adr_seen;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    adr_seen = adr_a & cs_a;
    reset = 1'b1;
    init0 = init_cnt_a;
    done0 = done_cnt_a;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (adr_seen !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_wr_key: adress&CS=%b before reset, required 1", adr_seen);
    end
    checks++;
    if (cs_a !== 1'b0 || ready_a !== 1'b1 || (data_a !== 32'h0 && data_a !== {32{1'bz}})) begin
      failures++;
      $display("FAIL abort_idle: cs=%b ready=%b data=%h, required 0 1 z", cs_a, ready_a, data_a);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (init_cnt_a !== init0 || done_cnt_a !== done0) begin
      failures++;
      $display("FAIL abort_no_pulses: initiates=%0d dones=%0d, required 0 0",
               init_cnt_a - init0, done_cnt_a - done0);
    end
  endtask

  task automatic test_latency_zero();
    int t0;
    int t_init = -1;
    int t_rd = -1;
    int t_done = -1;
    msg = FIPS_MSG;
    key = FIPS_KEY;
    @(negedge clk);
    start_b = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 40 && t_done < 0; i++) begin
      if (init_b && t_init < 0) t_init = cyc;
      if (cs_b && !rw_b && t_rd < 0) t_rd = cyc;
      if (done_b) t_done = cyc;
      if (t_done < 0) @(negedge clk);
    end
    checks++;
    if (t_done - t0 !== 14) begin
      failures++;
      $display("FAIL lat0_latency: got %0d cycles, required 14", t_done - t0);
    end
    checks++;
    if (t_init < 0 || t_rd - t_init !== 1) begin
      failures++;
      $display("FAIL lat0_rd_after_start: got gap %0d, required 1", t_rd - t_init);
    end
    @(negedge clk);
    checks++;
    if (cipher_b !== FIPS_CT) begin
      failures++;
      $display("FAIL lat0_cipher: got %h, required %h", cipher_b, FIPS_CT);
    end
  endtask

  task automatic test_bus();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL bus_ownership: got %0d violations, required 0", viol);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_fips();
    test_back_to_back();
    test_abort();
    test_latency_zero();
    test_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
